logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) among four requesters inside the ALU datapath.
- Round-robin arbitration, a one-cycle grant pulse, a registered result and a valid/ready response channel.
- Sits between the instruction-side requesters and the shared logic slice, so only one slice is instantiated per core.

Parameters:
- WIDTH, 32, operand/result width in bits
- CNTW, 16, width of the completed-operation counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  4  per-requester request; bit i belongs to requester i
- req_a  input  4*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  input  4*WIDTH  operand B; same packing as req_a
- req_op  input  8  opcode; requester i uses bits [2i +: 2]; 00 AND, 01 OR, 10 XOR, 11 NOR
- ack  output  4  one-hot, one-cycle acceptance pulse to the granted requester
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts the result
- rsp_id  output  2  requester index that owns rsp_y
- rsp_y  output  WIDTH  operation result
- busy  output  1  high whenever state is not IDLE
- op_count  output  CNTW  number of completed responses; wraps modulo 2^CNTW

Behaviour:
- Reset (async, rst=1): state=IDLE, ptr=0, ack=0, rsp_valid=0, rsp_id=0, rsp_y=0, busy=0, op_count=0, operand latches=0.
  - Asserting rst mid-operation discards the in-flight op; no response is issued.
- States: IDLE, EXEC, RESP.
- IDLE, no req bits set: stay in IDLE.
- IDLE, at least one req bit set at edge T:
  - Winner = first set bit searching ptr, ptr+1, ... modulo 4.
  - Latch that requester's A, B, op and index.
  - ack[winner]=1 during cycle T+1 only.
  - Next state EXEC.
- EXEC (cycle T+1): at its closing edge, rsp_y <= op(A_lat, B_lat), rsp_id <= index, rsp_valid <= 1. Next state RESP.
- RESP (cycle T+2 onward):
  - rsp_valid, rsp_id and rsp_y are held stable while rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid <= 0, op_count <= op_count+1, ptr <= index+1 mod 4, next state IDLE.
- Latency and throughput:
  - Request sampled to rsp_valid: 2 cycles.
  - With rsp_ready tied high, each requester is served at most once per 3 cycles; back-to-back ops are accepted every 3 cycles.
- Requester rules:
  - Hold req, operands and op stable until ack is seen.
  - Deassert req in the ack cycle.
  - req still high when the arbiter returns to IDLE is treated as a new request.
- Requests arriving in EXEC or RESP are ignored until IDLE; no queuing.
- Fairness: the last-served requester has lowest priority next. Under saturating requests from all four, the grant order is 0,1,2,3,0,...
- ptr wrap: after serving index 3, ptr becomes 0.
- op_count wraps from 2^CNTW-1 to 0 with no flag.
- busy = (state != IDLE), combinational from state.
- rsp_ready asserted outside RESP has no effect.
- Operand packing:
  - Requester 0 uses req_a[WIDTH-1:0].
  - Requester 3 uses req_a[4*WIDTH-1:3*WIDTH].

Test Plan:
- Reset, then req=0001, A0=32'hFFFF0000, B0=32'h0F0F0F0F, op0=10, rsp_ready=1 -> ack=0001 one cycle later; rsp_valid=1 two cycles after the request, with rsp_id=0, rsp_y=32'hF0F00F0F; op_count=1 after the handshake.
- All four req held high continuously with rsp_ready=1 and re-asserted after each ack -> ack sequence 0001,0010,0100,1000,0001, one grant every 3 cycles.
- req=0100, A2=32'h12345678, B2=32'h0000FFFF, op2=11, rsp_ready=0 for 5 cycles -> rsp_valid stays 1 with rsp_id=2 and rsp_y=32'hEDCB0000 stable; busy=1; no new ack even though req=0001 is asserted meanwhile.
- Each opcode 00/01/10/11 with A=32'hAAAA5555, B=32'h0F0FF0F0 -> rsp_y = 32'h0A0A5050, 32'hAFAFF5F5, 32'hA5A5A5A5, 32'h50500A0A.
- rst pulsed in EXEC -> rsp_valid never rises; all outputs return to 0; ptr=0, so req=1001 next grants requester 0.
- Preload op_count to 16'hFFFF by running 65535 ops, then one more op -> op_count=16'h0000.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic slice (AND/OR/XOR/NOR) among
// four requesters, with a one-cycle ack pulse and a registered valid/ready response.
module logic_unit_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   req_a,
    input  logic [4*WIDTH-1:0]   req_b,
    input  logic [7:0]           req_op,
    output logic [3:0]           ack,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [WIDTH-1:0]     rsp_y,
    output logic                 busy,
    output logic [CNTW-1:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         ptr_r;
    logic [WIDTH-1:0]   a_lat_r;
    logic [WIDTH-1:0]   b_lat_r;
    logic [1:0]         op_lat_r;
    logic [1:0]         id_lat_r;
    logic [3:0]         ack_r;
    logic               rsp_valid_r;
    logic [1:0]         rsp_id_r;
    logic [WIDTH-1:0]   rsp_y_r;
    logic [CNTW-1:0]    op_count_r;
    logic [3:0]         rot_s;
    logic [1:0]         off_s;
    logic [1:0]         win_idx_s;

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] y;
        case (op)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            2'b11:   y = ~(a | b);
            default: y = '0;
        endcase
        return y;
    endfunction

    // Rotate requests so bit 0 is the current highest-priority requester.
    assign rot_s = 4'({req, req} >> ptr_r);

    // Priority pick on the rotated vector, then map back to a requester index.
    always_comb begin
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        win_idx_s = ptr_r + off_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand latching, result register, pointer and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r       <= 2'd0;
            a_lat_r     <= '0;
            b_lat_r     <= '0;
            op_lat_r    <= 2'd0;
            id_lat_r    <= 2'd0;
            ack_r       <= 4'b0000;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 2'd0;
            rsp_y_r     <= '0;
            op_count_r  <= '0;
        end else begin
            ack_r <= 4'b0000;
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        a_lat_r  <= req_a[win_idx_s*WIDTH +: WIDTH];
                        b_lat_r  <= req_b[win_idx_s*WIDTH +: WIDTH];
                        op_lat_r <= req_op[win_idx_s*2 +: 2];
                        id_lat_r <= win_idx_s;
                        ack_r    <= 4'b0001 << win_idx_s;
                    end
                end
                EXEC: begin
                    rsp_y_r     <= logic_op(op_lat_r, a_lat_r, b_lat_r);
                    rsp_id_r    <= id_lat_r;
                    rsp_valid_r <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        op_count_r  <= op_count_r + {{(CNTW-1){1'b0}}, 1'b1};
                        // The requester just served drops to lowest priority.
                        ptr_r       <= id_lat_r + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack       = ack_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_y     = rsp_y_r;
    assign op_count  = op_count_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_logic_unit_arbiter;

    localparam int W  = 32;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [4*W-1:0]   req_a;
    logic [4*W-1:0]   req_b;
    logic [7:0]       req_op;
    logic [3:0]       ack;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_y;
    logic             busy;
    logic [CW-1:0]    op_count;

    int checks   = 0;
    int failures = 0;

    logic_unit_arbiter #(.WIDTH(W), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .ack(ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [1:0]  id;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ack;
        logic [31:0] y;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_opnd(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op);
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_op[2*i +: 2] = op;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_ack"},   64'(ack),       64'd0);
        check({nm, "_valid"}, 64'(rsp_valid), 64'd0);
        check({nm, "_id"},    64'(rsp_id),    64'd0);
        check({nm, "_y"},     64'(rsp_y),     64'd0);
        check({nm, "_busy"},  64'(busy),      64'd0);
        check({nm, "_cnt"},   64'(op_count),  64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        if (op == 2'd0)      return a & b;
        else if (op == 2'd1) return a | b;
        else if (op == 2'd2) return a ^ b;
        else                 return ~(a | b);
    endfunction

    function automatic int pick(input logic [3:0] p, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (p[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    logic [31:0] ma[4];
    logic [31:0] mb[4];
    logic [1:0]  mop[4];
    logic [3:0]  pending;
    logic [3:0]  nw;
    logic [31:0] exp_y;
    int          mptr;
    int          total;
    int          w;
    int          stall;

    initial begin
        vecs[0] = '{4'b0001, 2'd0, 2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 4'b0001, 32'hF0F00F0F};
        vecs[1] = '{4'b0010, 2'd1, 2'b00, 32'hAAAA5555, 32'h0F0FF0F0, 4'b0010, 32'h0A0A5050};
        vecs[2] = '{4'b0100, 2'd2, 2'b01, 32'hAAAA5555, 32'h0F0FF0F0, 4'b0100, 32'hAFAFF5F5};
        vecs[3] = '{4'b1000, 2'd3, 2'b10, 32'hAAAA5555, 32'h0F0FF0F0, 4'b1000, 32'hA5A5A5A5};
        vecs[4] = '{4'b0001, 2'd0, 2'b11, 32'hAAAA5555, 32'h0F0FF0F0, 4'b0001, 32'h50500A0A};

        req_a = '0;
        req_b = '0;
        req_op = 8'd0;
        do_reset();
        check_zero("reset");

        // Directed vectors, one requester at a time, consumer always ready.
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_opnd(int'(vecs[i].id), vecs[i].a, vecs[i].b, vecs[i].op);
            req = vecs[i].req;
            tick();
            check("vec_ack", 64'(ack), 64'(vecs[i].ack));
            check("vec_busy", 64'(busy), 64'd1);
            req = 4'b0000;
            tick();
            check("vec_ack_pulse", 64'(ack), 64'd0);
            check("vec_valid", 64'(rsp_valid), 64'd1);
            check("vec_id", 64'(rsp_id), 64'(vecs[i].id));
            check("vec_y", 64'(rsp_y), 64'(vecs[i].y));
            tick();
            check("vec_valid_drop", 64'(rsp_valid), 64'd0);
            check("vec_idle", 64'(busy), 64'd0);
            check("vec_cnt", 64'(op_count), 64'(i + 1));
        end

        // Saturating requests: grants rotate 0,1,2,3,0 every third cycle.
        do_reset();
        rsp_ready = 1'b1;
        req = 4'b1111;
        for (int j = 0; j < 15; j++) begin
            tick();
            check("sat_ack", 64'(ack), (j % 3 == 0) ? 64'(4'b0001 << ((j / 3) % 4)) : 64'd0);
            if (j % 3 == 1) check("sat_id", 64'(rsp_id), 64'((j / 3) % 4));
        end
        req = 4'b0000;
        check("sat_cnt", 64'(op_count), 64'd5);

        // Stalled consumer: response held, later request ignored until IDLE.
        set_opnd(2, 32'h12345678, 32'h0000FFFF, 2'b11);
        set_opnd(0, 32'h00000001, 32'h00000002, 2'b01);
        req = 4'b0100;
        rsp_ready = 1'b0;
        tick();
        check("stall_ack", 64'(ack), 64'b0100);
        req = 4'b0001;
        tick();
        check("stall_valid0", 64'(rsp_valid), 64'd1);
        for (int j = 0; j < 5; j++) begin
            tick();
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_id", 64'(rsp_id), 64'd2);
            check("stall_y", 64'(rsp_y), 64'hEDCB0000);
            check("stall_busy", 64'(busy), 64'd1);
            check("stall_noack", 64'(ack), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check("stall_release", 64'(rsp_valid), 64'd0);
        tick();
        check("stall_next_ack", 64'(ack), 64'b0001);
        req = 4'b0000;
        tick();
        check("stall_next_y", 64'(rsp_y), 64'h00000003);
        tick();

        // Reset while in EXEC drops the operation and the pointer.
        req = 4'b1000;
        tick();
        check("rexec_ack", 64'(ack), 64'b1000);
        req = 4'b0000;
        rst = 1'b1;
        #1;
        check_zero("rexec");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("rexec_novalid", 64'(rsp_valid), 64'd0);
        end
        req = 4'b1001;
        tick();
        check("rexec_ptr0", 64'(ack), 64'b0001);
        req = 4'b0000;
        tick();
        tick();

        // Randomized traffic against the transaction-level model.
        do_reset();
        pending = 4'b0000;
        mptr = 0;
        total = 0;
        for (int t = 0; t < 40; t++) begin
            nw = 4'($urandom_range(0, 15));
            if ((pending | nw) == 4'b0000) nw[$urandom_range(0, 3)] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (nw[i] && !pending[i]) begin
                    ma[i] = $urandom;
                    mb[i] = $urandom;
                    mop[i] = 2'($urandom_range(0, 3));
                    set_opnd(i, ma[i], mb[i], mop[i]);
                end
            end
            pending = pending | nw;
            req = pending;
            tick();
            w = pick(pending, mptr);
            exp_y = ref_op(mop[w], ma[w], mb[w]);
            check("rnd_ack", 64'(ack), 64'(4'b0001 << w));
            pending[w] = 1'b0;
            req = pending;
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            check("rnd_valid", 64'(rsp_valid), 64'd1);
            check("rnd_id", 64'(rsp_id), 64'(w));
            check("rnd_y", 64'(rsp_y), 64'(exp_y));
            stall = $urandom_range(0, 3);
            rsp_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                tick();
                check("rnd_hold_valid", 64'(rsp_valid), 64'd1);
                check("rnd_hold_y", 64'(rsp_y), 64'(exp_y));
                check("rnd_hold_ack", 64'(ack), 64'd0);
            end
            rsp_ready = 1'b1;
            tick();
            total++;
            check("rnd_drop", 64'(rsp_valid), 64'd0);
            check("rnd_cnt", 64'(op_count), 64'(total % (1 << CW)));
            mptr = (w + 1) % 4;
        end
        req = 4'b0000;

        // Counter wrap.
        set_opnd(0, 32'h0000FFFF, 32'h00FF00FF, 2'b00);
        rsp_ready = 1'b1;
        while ((total % (1 << CW)) != ((1 << CW) - 1)) begin
            req = 4'b0001;
            tick();
            req = 4'b0000;
            tick();
            tick();
            total++;
        end
        check("wrap_max", 64'(op_count), 64'((1 << CW) - 1));
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        check("wrap_y", 64'(rsp_y), 64'h000000FF);
        tick();
        check("wrap_zero", 64'(op_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
